vit_frame_sequencer: RTL and testbench

- Frame-level controller in front of the (2,1,3) Viterbi decoder core (BMU/ACSU/control top).
- Per frame, the block:
  - clears the core;
  - streams FRAME_LEN received symbols into it, then TAIL zero symbols to terminate the trellis;
  - collects the core's enabled decoded bits, strips the tail bits and reports frame status.
- The core has no clock enable and consumes one symbol per clock, so this block owns its input pacing.

---
 rtl/vit_frame_sequencer.sv | 167 ++++++++++++++++
 tb/tb_vit_frame_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vit_frame_sequencer.sv
// Frame-level controller in front of a (2,1,3) Viterbi core: clears the core, streams
// FRAME_LEN symbols plus a zero tail, collects the decoded bits and reports frame status.
module vit_frame_sequencer #(
  parameter int N         = 2,
  parameter int FRAME_LEN = 64,
  parameter int TAIL      = 2,
  parameter int CLR_CYC   = 2,
  parameter int TMO       = 64
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  output logic         busy,
  input  logic [N-1:0] in_sym,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] core_rx,
  output logic         core_reset,
  input  logic         core_dx,
  input  logic         core_dx_oe,
  input  logic         core_error,
  output logic         out_bit,
  output logic         out_valid,
  output logic         out_last,
  output logic         frame_done,
  output logic         frame_err,
  output logic [1:0]   err_code
);

  localparam int SymW  = ($clog2(FRAME_LEN + 1) > 0) ? $clog2(FRAME_LEN + 1) : 1;
  localparam int TailW = ($clog2(TAIL + 1) > 0) ? $clog2(TAIL + 1) : 1;
  localparam int ClrW  = ($clog2(CLR_CYC + 1) > 0) ? $clog2(CLR_CYC + 1) : 1;
  localparam int TmoW  = ($clog2(TMO + 1) > 0) ? $clog2(TMO + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LOAD, S_TAIL, S_DRAIN, S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [ClrW-1:0]  clrCnt_q, clrCnt_d;
  logic [SymW-1:0]  symCnt_q, symCnt_d;
  logic [TailW-1:0] tailCnt_q, tailCnt_d;
  logic [TmoW-1:0]  tmoCnt_q, tmoCnt_d;
  logic [SymW-1:0]  outCnt_q, outCnt_d;
  logic             coreErr_q, coreErr_d;
  logic [N-1:0]     coreRx_q, coreRx_d;
  logic             coreReset_q, coreReset_d;
  logic             outBit_q, outBit_d;
  logic             outValid_q, outValid_d;
  logic             outLast_q, outLast_d;
  logic             frameErr_q, frameErr_d;
  logic [1:0]       errCode_q, errCode_d;

  logic collecting, accept, underrun, symDone, clrDone, tailDone, timeout;
  logic emitBit, lastBit;

  // The core cannot be stalled, so a missing symbol during LOAD aborts the frame.
  assign collecting = (state_q == S_LOAD) || (state_q == S_TAIL) || (state_q == S_DRAIN);
  assign accept     = (state_q == S_LOAD) && in_valid;
  assign underrun   = (state_q == S_LOAD) && !in_valid;
  assign symDone    = accept && (symCnt_q == SymW'(FRAME_LEN - 1));
  assign clrDone    = (state_q == S_CLEAR) && (clrCnt_q == ClrW'(CLR_CYC - 1));
  assign tailDone   = (state_q == S_TAIL) && (tailCnt_q == TailW'(TAIL - 1));
  assign timeout    = (state_q == S_DRAIN) && (tmoCnt_q == TmoW'(TMO - 1));
  assign emitBit    = collecting && core_dx_oe && (outCnt_q < SymW'(FRAME_LEN));
  assign lastBit    = emitBit && (outCnt_q == SymW'(FRAME_LEN - 1));

  always_ff @(posedge clock) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // A completed frame wins over an underrun or timeout landing on the same edge.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_CLEAR;
      S_CLEAR: if (clrDone) state_d = S_LOAD;
      S_LOAD: begin
        if (lastBit || underrun) state_d = S_DONE;
        else if (symDone)        state_d = (TAIL > 0) ? S_TAIL : S_DRAIN;
      end
      S_TAIL: begin
        if (lastBit)       state_d = S_DONE;
        else if (tailDone) state_d = S_DRAIN;
      end
      S_DRAIN: if (lastBit || timeout) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q != S_IDLE);
    in_ready    = (state_q == S_LOAD);
    frame_done  = (state_q == S_DONE);
    coreRx_d    = accept ? in_sym : '0;
    coreReset_d = collecting || clrDone;
    outValid_d  = emitBit;
    outBit_d    = emitBit && core_dx;
    outLast_d   = lastBit;
    errCode_d   = errCode_q;
    frameErr_d  = frameErr_q;
    if (lastBit) begin
      errCode_d  = (coreErr_q || core_error) ? 2'd3 : 2'd0;
      frameErr_d = coreErr_q || core_error;
    end else if (underrun) begin
      errCode_d  = 2'd1;
      frameErr_d = 1'b1;
    end else if (timeout) begin
      errCode_d  = 2'd2;
      frameErr_d = 1'b1;
    end
  end

  // Every counter is zero outside its own state, so each starts clean on entry.
  always_comb begin
    clrCnt_d  = (state_q == S_CLEAR) ? clrCnt_q + 1'b1 : '0;
    symCnt_d  = (state_q == S_LOAD)  ? symCnt_q + SymW'(accept) : '0;
    tailCnt_d = (state_q == S_TAIL)  ? tailCnt_q + 1'b1 : '0;
    tmoCnt_d  = (state_q == S_DRAIN) ? tmoCnt_q + 1'b1 : '0;
    outCnt_d  = collecting ? outCnt_q + SymW'(emitBit) : '0;
    coreErr_d = collecting && (coreErr_q || core_error);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      clrCnt_q    <= '0;
      symCnt_q    <= '0;
      tailCnt_q   <= '0;
      tmoCnt_q    <= '0;
      outCnt_q    <= '0;
      coreErr_q   <= 1'b0;
      coreRx_q    <= '0;
      coreReset_q <= 1'b0;
      outBit_q    <= 1'b0;
      outValid_q  <= 1'b0;
      outLast_q   <= 1'b0;
      frameErr_q  <= 1'b0;
      errCode_q   <= 2'd0;
    end else begin
      clrCnt_q    <= clrCnt_d;
      symCnt_q    <= symCnt_d;
      tailCnt_q   <= tailCnt_d;
      tmoCnt_q    <= tmoCnt_d;
      outCnt_q    <= outCnt_d;
      coreErr_q   <= coreErr_d;
      coreRx_q    <= coreRx_d;
      coreReset_q <= coreReset_d;
      outBit_q    <= outBit_d;
      outValid_q  <= outValid_d;
      outLast_q   <= outLast_d;
      frameErr_q  <= frameErr_d;
      errCode_q   <= errCode_d;
    end
  end

  assign core_rx    = coreRx_q;
  assign core_reset = coreReset_q;
  assign out_bit    = outBit_q;
  assign out_valid  = outValid_q;
  assign out_last   = outLast_q;
  assign frame_err  = frameErr_q;
  assign err_code   = errCode_q;

endmodule

// File: tb/tb_vit_frame_sequencer.sv
// Bench for vit_frame_sequencer: frames are described per cycle, a frame-timeline model
// predicts the decoded-bit and frame-status events, and a monitor matches them as they appear.
module tb_vit_frame_sequencer;
  localparam int N    = 2;
  localparam int FL   = 8;
  localparam int TL   = 2;
  localparam int CLR  = 2;
  localparam int TMO  = 16;
  localparam int L0   = CLR + 1;
  localparam int T0   = L0 + FL;
  localparam int D0   = T0 + TL;
  localparam int MAXC = D0 + TMO + 4;

  logic         clock = 1'b0;
  logic         reset, start, in_valid, core_dx, core_dx_oe, core_error;
  logic [N-1:0] in_sym;
  logic         busy, in_ready, core_reset, out_bit, out_valid, out_last;
  logic         frame_done, frame_err;
  logic [N-1:0] core_rx;
  logic [1:0]   err_code;

  vit_frame_sequencer #(.N(N), .FRAME_LEN(FL), .TAIL(TL), .CLR_CYC(CLR), .TMO(TMO)) dut (
    .clock(clock), .reset(reset), .start(start), .busy(busy),
    .in_sym(in_sym), .in_valid(in_valid), .in_ready(in_ready),
    .core_rx(core_rx), .core_reset(core_reset),
    .core_dx(core_dx), .core_dx_oe(core_dx_oe), .core_error(core_error),
    .out_bit(out_bit), .out_valid(out_valid), .out_last(out_last),
    .frame_done(frame_done), .frame_err(frame_err), .err_code(err_code)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int cycle;
    bit isDone;
    bit val;
    bit last;
    int code;
  } expEvent_t;

  expEvent_t expQ[$];
  expEvent_t monE;

  int checks = 0;
  int errors = 0;
  int prevCode = 0;

  bit           ivArr[MAXC];
  bit           oeArr[MAXC];
  bit           dxArr[MAXC];
  bit           errArr[MAXC];
  bit           stArr[MAXC];
  logic [N-1:0] symArr[MAXC];

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (out_valid) begin
      if (expQ.size() == 0) checkOutput("spurious out_valid", 1, 0);
      else begin
        monE = expQ.pop_front();
        checkOutput("event kind bit", 0, int'(monE.isDone));
        checkOutput("out_valid cycle", cyc, monE.cycle);
        checkOutput("out_bit", int'(out_bit), int'(monE.val));
        checkOutput("out_last", int'(out_last), int'(monE.last));
      end
    end
    if (frame_done) begin
      if (expQ.size() == 0) checkOutput("spurious frame_done", 1, 0);
      else begin
        monE = expQ.pop_front();
        checkOutput("event kind done", 1, int'(monE.isDone));
        checkOutput("frame_done cycle", cyc, monE.cycle);
        checkOutput("frame_err", int'(frame_err), int'(monE.code != 0));
        checkOutput("err_code", int'(err_code), monE.code);
      end
    end
  end

  // Encoded info bits 1,0,1,1,0,0,1,0 with the core answering 4 cycles into LOAD.
  task automatic genNominal();
    bit [7:0] info;
    bit s0, s1, b;
    info = 8'b0100_1101;
    s0 = 1'b0;
    s1 = 1'b0;
    for (int c = 0; c < MAXC; c++) begin
      ivArr[c]  = 1'b1;
      oeArr[c]  = 1'b0;
      dxArr[c]  = 1'b0;
      errArr[c] = 1'b0;
      stArr[c]  = 1'b0;
      symArr[c] = '0;
    end
    stArr[0] = 1'b1;
    for (int k = 0; k < FL; k++) begin
      b = info[k];
      symArr[L0 + k] = {b ^ s0 ^ s1, b ^ s1};
      s1 = s0;
      s0 = b;
    end
    for (int k = 0; k < FL + TL; k++) begin
      oeArr[L0 + 4 + k] = 1'b1;
      dxArr[L0 + 4 + k] = (k < FL) ? info[k] : 1'b0;
    end
  endtask

  task automatic genRandom();
    int underPct, oePct;
    underPct = ($urandom_range(0, 3) == 0) ? 8 : 0;
    oePct    = $urandom_range(30, 75);
    for (int c = 0; c < MAXC; c++) begin
      stArr[c]  = ($urandom_range(0, 9) == 0);
      symArr[c] = N'($urandom);
      ivArr[c]  = ($urandom_range(0, 99) >= underPct);
      oeArr[c]  = ($urandom_range(0, 99) < oePct);
      dxArr[c]  = $urandom_range(0, 1);
      errArr[c] = ($urandom_range(0, 29) == 0);
    end
    stArr[0] = 1'b1;
  endtask

  // Runs one frame from an IDLE cycle (frame cycle 0 = start sampled); resetAt>=0 pulses reset then.
  task automatic applyStimulus(input int resetAt);
    int base, cnt, doneC, code, lastC, expRx;
    bit sticky;
    expEvent_t e;
    base   = cyc;
    cnt    = 0;
    sticky = 1'b0;
    doneC  = -1;
    code   = 0;
    for (int c = L0; doneC < 0; c++) begin
      if (oeArr[c] && cnt < FL) begin
        e.cycle  = base + c + 1;
        e.isDone = 1'b0;
        e.val    = dxArr[c];
        e.last   = (cnt == FL - 1);
        e.code   = 0;
        if (resetAt < 0) expQ.push_back(e);
        cnt++;
        if (cnt == FL) begin
          doneC = c + 1;
          code  = (sticky || errArr[c]) ? 3 : 0;
        end
      end
      if (doneC < 0 && c < T0 && !ivArr[c]) begin
        doneC = c + 1;
        code  = 1;
      end
      if (doneC < 0 && c == D0 + TMO - 1) begin
        doneC = c + 1;
        code  = 2;
      end
      sticky = sticky || errArr[c];
    end
    if (resetAt < 0) begin
      e.cycle  = base + doneC;
      e.isDone = 1'b1;
      e.val    = 1'b0;
      e.last   = 1'b0;
      e.code   = code;
      expQ.push_back(e);
    end
    lastC = (resetAt >= 0) ? resetAt + 1 : doneC;
    for (int c = 0; c <= lastC; c++) begin
      start      = stArr[c];
      in_valid   = ivArr[c];
      in_sym     = symArr[c];
      core_dx_oe = oeArr[c];
      core_dx    = dxArr[c];
      core_error = errArr[c];
      reset      = (c == resetAt) ? 1'b0 : 1'b1;
      if (resetAt >= 0 && c == resetAt + 1) begin
        start = 1'b0;
        checkOutput("busy after reset", int'(busy), 0);
        checkOutput("out_valid after reset", int'(out_valid), 0);
        checkOutput("core_reset after reset", int'(core_reset), 0);
        checkOutput("frame_done after reset", int'(frame_done), 0);
        checkOutput("in_ready after reset", int'(in_ready), 0);
        checkOutput("err_code after reset", int'(err_code), 0);
      end else begin
        expRx = (c - 1 >= L0 && c - 1 < T0 && ivArr[c - 1]) ? int'(symArr[c - 1]) : 0;
        checkOutput("busy", int'(busy), int'(c >= 1));
        checkOutput("in_ready", int'(in_ready), int'(c >= L0 && c < T0 && c < doneC));
        checkOutput("core_reset", int'(core_reset), int'(c >= L0));
        checkOutput("core_rx", int'(core_rx), expRx);
        checkOutput("err_code hold", int'(err_code), (c >= doneC) ? code : prevCode);
      end
      @(posedge clock);
      #1;
    end
    prevCode = (resetAt >= 0) ? 0 : code;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_sym = '0;
    core_dx = 1'b0; core_dx_oe = 1'b0; core_error = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset in_ready", int'(in_ready), 0);
    checkOutput("reset core_rx", int'(core_rx), 0);
    checkOutput("reset core_reset", int'(core_reset), 0);
    checkOutput("reset out_bit", int'(out_bit), 0);
    checkOutput("reset out_valid", int'(out_valid), 0);
    checkOutput("reset out_last", int'(out_last), 0);
    checkOutput("reset frame_done", int'(frame_done), 0);
    checkOutput("reset frame_err", int'(frame_err), 0);
    checkOutput("reset err_code", int'(err_code), 0);
    reset = 1'b1;
    @(posedge clock);
    #1;

    genNominal(); applyStimulus(-1);
    genNominal(); ivArr[L0 + 4] = 1'b0; applyStimulus(-1);
    genNominal(); for (int c = 0; c < MAXC; c++) oeArr[c] = 1'b0; applyStimulus(-1);
    genNominal(); errArr[L0 + 3] = 1'b1; applyStimulus(-1);
    genNominal(); stArr[L0 + 2] = 1'b1; stArr[L0 + 5] = 1'b1; applyStimulus(-1);
    for (int f = 0; f < 2; f++) begin
      genNominal();
      for (int c = 0; c < MAXC; c++) stArr[c] = 1'b1;
      applyStimulus(-1);
    end
    genNominal(); for (int c = 0; c < MAXC; c++) oeArr[c] = 1'b0; applyStimulus(D0 + 3);
    genNominal(); applyStimulus(-1);

    repeat (40) begin
      genRandom();
      applyStimulus(-1);
    end

    start = 1'b0; core_dx_oe = 1'b0; in_valid = 1'b0; core_error = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    checkOutput("pending expectations", expQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
